// File: rtl/decoder_7_2_pkg.sv
// Shared widths for the 7-bit / 9-TSV CAC receive decoder.
// Latency: n/a (constants and a width helper only).
// Backpressure: n/a.
//
// Holds the BLEN/FNSLEN widths used by the coder/decoder pair and the
// helper that sizes the internal weighted-sum datapath.
package decoder_7_2_pkg;

    localparam int BLEN_07   = 7;   // decoded data width
    localparam int FNSLEN_08 = 8;   // width of one FNS weight
    localparam int CODEW_09  = 9;   // TSV codeword width (x+y)
    localparam int ERRCW_08  = 8;   // range-error counter width

    // Nine weights of at most FNS_W bits each sum to less than 2^(FNS_W+4),
    // so this width can never wrap regardless of the weight set loaded.
    function automatic int sum_width(input int data_w, input int fns_w);
        return ((data_w > fns_w) ? data_w : fns_w) + 4;
    endfunction

endpackage

// File: rtl/decoder_7_2_fns_wsum3.sv
// Three-bit masked weighted sum, registered (one S1 slice of the decoder).
// Latency: 1 cycle from i_load to o_psum.
// Backpressure: holds o_psum whenever i_load is low.
//
// Ports:
//   i_clock, i_reset_n   clock, synchronous active-low reset
//   i_load               load enable (pipeline advance)
//   i_bits, i_mask       three code bits and their per-TSV enables
//   i_w0..i_w2           weights of the three bits
//   o_psum               registered partial sum
module decoder_7_2_fns_wsum3
    import decoder_7_2_pkg::*;
#(
    parameter int FNS_W = FNSLEN_08,
    parameter int SUM_W = sum_width(BLEN_07, FNSLEN_08)
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_load,
    input  logic [2:0]       i_bits,
    input  logic [2:0]       i_mask,
    input  logic [FNS_W-1:0] i_w0,
    input  logic [FNS_W-1:0] i_w1,
    input  logic [FNS_W-1:0] i_w2,
    output logic [SUM_W-1:0] o_psum
);

    logic [2:0]       w_on;
    logic [SUM_W-1:0] w_psum;
    logic [SUM_W-1:0] r_psum;

    // A line contributes only when it carries a 1 and is not flagged faulty.
    assign w_on = i_bits & i_mask;

    always_comb begin
        w_psum = '0;
        if (w_on[0]) w_psum = w_psum + SUM_W'(i_w0);
        if (w_on[1]) w_psum = w_psum + SUM_W'(i_w1);
        if (w_on[2]) w_psum = w_psum + SUM_W'(i_w2);
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_psum <= '0;
        end else if (i_load) begin
            r_psum <= w_psum;
        end
    end

    assign o_psum = r_psum;

endmodule

// File: rtl/decoder_7_2.sv
// Receive-side inverse of the 7-bit/9-TSV local-AFNS CAC coder.
// Latency: 2 cycles accept-to-out_valid, 1 word/cycle throughput.
// Backpressure: global stall; in_ready = !out_valid | out_ready, output held while stalled.
//
// Ports:
//   i_clock, i_reset_n          clock, synchronous active-low reset
//   i_in_valid / o_in_ready     input handshake for i_codein + i_en_flag
//   i_codein, i_en_flag         received TSV codeword and per-TSV enable mask
//   i_fns02..i_fns09            FNS weights of code bits 1..8 (quasi-static)
//   o_out_valid / i_out_ready   output handshake
//   o_dataout, o_range_err      decoded word and its out-of-range flag
//   o_err_cnt, i_err_clr        saturating count of delivered range errors, clear
module decoder_7_2
    import decoder_7_2_pkg::*;
#(
    parameter int DATA_W = BLEN_07,
    parameter int CODE_W = CODEW_09,
    parameter int FNS_W  = FNSLEN_08,
    parameter int ERRC_W = ERRCW_08
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [CODE_W-1:0] i_codein,
    input  logic [CODE_W-1:0] i_en_flag,
    input  logic [FNS_W-1:0]  i_fns02,
    input  logic [FNS_W-1:0]  i_fns03,
    input  logic [FNS_W-1:0]  i_fns04,
    input  logic [FNS_W-1:0]  i_fns05,
    input  logic [FNS_W-1:0]  i_fns06,
    input  logic [FNS_W-1:0]  i_fns07,
    input  logic [FNS_W-1:0]  i_fns08,
    input  logic [FNS_W-1:0]  i_fns09,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_dataout,
    output logic              o_range_err,
    output logic [ERRC_W-1:0] o_err_cnt,
    input  logic              i_err_clr
);

    localparam int SUM_W = sum_width(DATA_W, FNS_W);
    localparam logic [FNS_W-1:0] W_BIT0 = FNS_W'(1);

    logic             w_adv;
    logic             w_accept;
    logic             w_fire_err;
    logic [SUM_W-1:0] w_p0;
    logic [SUM_W-1:0] w_p1;
    logic [SUM_W-1:0] w_p2;
    logic [SUM_W-1:0] w_sum;

    logic              r_s1_vld;
    logic              r_out_vld;
    logic [SUM_W-1:0]  r_sum;
    logic [ERRC_W-1:0] r_err_cnt;

    // Both stages move together; a bubble in S1 is carried, not squeezed.
    assign w_adv    = !r_out_vld || i_out_ready;
    assign w_accept = i_in_valid && w_adv;

    // S1: three registered partial sums. The weights are captured here, so a
    // word that has left S1 is unaffected by later FNS changes.
    decoder_7_2_fns_wsum3 #(.FNS_W(FNS_W), .SUM_W(SUM_W)) u_p0 (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_load    (w_adv),
        .i_bits    (i_codein[2:0]),
        .i_mask    (i_en_flag[2:0]),
        .i_w0      (W_BIT0),
        .i_w1      (i_fns02),
        .i_w2      (i_fns03),
        .o_psum    (w_p0)
    );

    decoder_7_2_fns_wsum3 #(.FNS_W(FNS_W), .SUM_W(SUM_W)) u_p1 (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_load    (w_adv),
        .i_bits    (i_codein[5:3]),
        .i_mask    (i_en_flag[5:3]),
        .i_w0      (i_fns04),
        .i_w1      (i_fns05),
        .i_w2      (i_fns06),
        .o_psum    (w_p1)
    );

    decoder_7_2_fns_wsum3 #(.FNS_W(FNS_W), .SUM_W(SUM_W)) u_p2 (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_load    (w_adv),
        .i_bits    (i_codein[8:6]),
        .i_mask    (i_en_flag[8:6]),
        .i_w0      (i_fns07),
        .i_w1      (i_fns08),
        .i_w2      (i_fns09),
        .o_psum    (w_p2)
    );

    assign w_sum = w_p0 + w_p1 + w_p2;

    // S2: final sum and output valid.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_s1_vld  <= 1'b0;
            r_out_vld <= 1'b0;
            r_sum     <= '0;
        end else if (w_adv) begin
            r_s1_vld  <= w_accept;
            r_out_vld <= r_s1_vld;
            r_sum     <= w_sum;
        end
    end

    // Any bit above the data field means the coder could not have produced it.
    assign o_dataout   = r_sum[DATA_W-1:0];
    assign o_range_err = |r_sum[SUM_W-1:DATA_W];
    assign o_out_valid = r_out_vld;
    assign o_in_ready  = w_adv;

    // Count only errored words actually handed to the sink.
    assign w_fire_err = r_out_vld && i_out_ready && o_range_err;

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_err_cnt <= '0;
        end else if (i_err_clr) begin
            r_err_cnt <= '0;
        end else if (w_fire_err && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + ERRC_W'(1);
        end
    end

    assign o_err_cnt = r_err_cnt;

endmodule

// File: tb/tb_decoder_7_2.sv
// Directed self-checking bench for decoder_7_2.
module tb_decoder_7_2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [8:0] codein = '0;
    logic [8:0] en_flag = '0;
    logic [7:0] fns02, fns03, fns04, fns05, fns06, fns07, fns08, fns09;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [6:0] dataout;
    logic       range_err;
    logic [7:0] err_cnt;
    logic       err_clr = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    decoder_7_2 dut (
        .i_clock     (clk),
        .i_reset_n   (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_codein    (codein),
        .i_en_flag   (en_flag),
        .i_fns02     (fns02),
        .i_fns03     (fns03),
        .i_fns04     (fns04),
        .i_fns05     (fns05),
        .i_fns06     (fns06),
        .i_fns07     (fns07),
        .i_fns08     (fns08),
        .i_fns09     (fns09),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_dataout   (dataout),
        .o_range_err (range_err),
        .o_err_cnt   (err_cnt),
        .i_err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_default_weights();
        fns02 = 8'd1;  fns03 = 8'd2;  fns04 = 8'd3;  fns05 = 8'd5;
        fns06 = 8'd8;  fns07 = 8'd13; fns08 = 8'd21; fns09 = 8'd34;
    endtask

    // Present one word for a single cycle and wait until it reaches S2.
    task automatic drive_word(input logic [8:0] code, input logic [8:0] en);
        codein = code; en_flag = en; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
        repeat (2) tick();
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_tests++;
        if (dataout !== 7'd0) begin n_fail++; $display("FAIL reset_dataout: got %0d expected 0", dataout); end
        n_tests++;
        if (range_err !== 1'b0) begin n_fail++; $display("FAIL reset_range_err: got %b expected 0", range_err); end
        n_tests++;
        if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
        rst_n = 1'b1;
        tick();
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_single_word();
        codein = 9'h101; en_flag = 9'h1FF; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_in_ready: got %b expected 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b expected 0", out_valid); end
        tick();
        n_tests++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid_lat2: got %b expected 1", out_valid); end
        n_tests++;
        if (dataout !== 7'd35) begin n_fail++; $display("FAIL single_dataout: got %0d expected 35", dataout); end
        n_tests++;
        if (range_err !== 1'b0) begin n_fail++; $display("FAIL single_range_err: got %b expected 0", range_err); end
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_drop: got %b expected 0", out_valid); end
    endtask

    task automatic test_masking();
        out_ready = 1'b1;
        drive_word(9'h1FF, 9'h0FF);
        n_tests++;
        if (out_valid !== 1'b1 || dataout !== 7'd54) begin
            n_fail++; $display("FAIL mask_0ff: got valid=%b data=%0d expected valid=1 data=54", out_valid, dataout);
        end
        drive_word(9'h1FF, 9'h000);
        n_tests++;
        if (out_valid !== 1'b1 || dataout !== 7'd0) begin
            n_fail++; $display("FAIL mask_000: got valid=%b data=%0d expected valid=1 data=0", out_valid, dataout);
        end
        drive_word(9'h1FF, 9'h1FF);
        n_tests++;
        if (out_valid !== 1'b1 || dataout !== 7'd88) begin
            n_fail++; $display("FAIL mask_1ff: got valid=%b data=%0d expected valid=1 data=88", out_valid, dataout);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1; en_flag = 9'h1FF;
        codein = 9'h000; in_valid = 1'b1;
        tick();
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready_1: got %b expected 1", in_ready); end
        codein = 9'h003;
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || dataout !== 7'd0) begin
            n_fail++; $display("FAIL b2b_word0: got valid=%b data=%0d expected valid=1 data=0", out_valid, dataout);
        end
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready_2: got %b expected 1", in_ready); end
        codein = 9'h1FF;
        tick();
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1 || dataout !== 7'd2) begin
            n_fail++; $display("FAIL b2b_word1: got valid=%b data=%0d expected valid=1 data=2", out_valid, dataout);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || dataout !== 7'd88) begin
            n_fail++; $display("FAIL b2b_word2: got valid=%b data=%0d expected valid=1 data=88", out_valid, dataout);
        end
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_backpressure();
        logic [8:0] codes [6];
        int         exp_d [6];
        int         got [$];
        int         sent = 0;
        int         cyc = 0;
        int         stalls = 0;
        logic       stalled;
        logic       acc;
        logic [6:0] held;
        codes = '{9'h001, 9'h004, 9'h008, 9'h010, 9'h020, 9'h040};
        exp_d = '{1, 2, 3, 5, 8, 13};
        en_flag = 9'h1FF;
        held = '0;
        while (got.size() < 6 && cyc < 40) begin
            in_valid  = (sent < 6);
            codein    = (sent < 6) ? codes[sent] : 9'h000;
            out_ready = !(cyc >= 3 && cyc < 6);
            #1;
            stalled = out_valid && !out_ready;
            if (stalled) begin
                stalls++;
                held = dataout;
                n_tests++;
                if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_stall: got %b expected 0 (cycle %0d)", in_ready, cyc); end
            end
            if (out_valid && out_ready) got.push_back(int'(dataout));
            acc = in_valid && in_ready;
            tick();
            if (acc) sent++;
            if (stalled) begin
                n_tests++;
                if (out_valid !== 1'b1 || dataout !== held) begin
                    n_fail++; $display("FAIL bp_hold: got valid=%b data=%0d expected valid=1 data=%0d", out_valid, dataout, held);
                end
            end
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_tests++;
        if (stalls != 3) begin n_fail++; $display("FAIL bp_stall_cycles: got %0d expected 3", stalls); end
        n_tests++;
        if (got.size() != 6) begin n_fail++; $display("FAIL bp_count: got %0d expected 6", got.size()); end
        for (int i = 0; i < 6; i++) begin
            if (i < got.size()) begin
                n_tests++;
                if (got[i] != exp_d[i]) begin n_fail++; $display("FAIL bp_order[%0d]: got %0d expected %0d", i, got[i], exp_d[i]); end
            end
        end
        repeat (2) tick();
    endtask

    task automatic test_range_error();
        fns08 = 8'd60; fns09 = 8'd100;
        out_ready = 1'b1;
        drive_word(9'h180, 9'h1FF);
        n_tests++;
        if (out_valid !== 1'b1 || dataout !== 7'd32 || range_err !== 1'b1) begin
            n_fail++; $display("FAIL rerr_word: got valid=%b data=%0d err=%b expected valid=1 data=32 err=1", out_valid, dataout, range_err);
        end
        n_tests++;
        if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL rerr_cnt_pre: got %0d expected 0", err_cnt); end
        tick();
        n_tests++;
        if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL rerr_cnt_one: got %0d expected 1", err_cnt); end
        // 300 more error words: 301 in total, so the counter must pin at 255.
        codein = 9'h180; in_valid = 1'b1;
        repeat (300) tick();
        in_valid = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (err_cnt !== 8'd255) begin n_fail++; $display("FAIL rerr_saturate: got %0d expected 255", err_cnt); end
        drive_word(9'h180, 9'h1FF);
        err_clr = 1'b1;
        n_tests++;
        if (out_valid !== 1'b1 || range_err !== 1'b1) begin
            n_fail++; $display("FAIL rerr_clr_setup: got valid=%b err=%b expected valid=1 err=1", out_valid, range_err);
        end
        tick();
        err_clr = 1'b0;
        n_tests++;
        if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL rerr_clr_wins: got %0d expected 0", err_cnt); end
    endtask

    task automatic test_reset_midop();
        int seen = 0;
        out_ready = 1'b1;
        drive_word(9'h180, 9'h1FF);
        tick();
        n_tests++;
        if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL midrst_cnt_pre: got %0d expected 1", err_cnt); end
        codein = 9'h180; in_valid = 1'b1;
        tick();
        codein = 9'h001;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_inflight: got %b expected 1", out_valid); end
        rst_n = 1'b0;
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
        n_tests++;
        if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL midrst_err_cnt: got %0d expected 0", err_cnt); end
        rst_n = 1'b1; out_ready = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
        repeat (5) begin
            tick();
            if (out_valid) seen++;
        end
        n_tests++;
        if (seen != 0) begin n_fail++; $display("FAIL midrst_no_emit: got %0d words expected 0", seen); end
        n_tests++;
        if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL midrst_err_cnt_after: got %0d expected 0", err_cnt); end
    endtask

    initial begin
        set_default_weights();
        test_reset();
        test_single_word();
        test_masking();
        test_back_to_back();
        test_backpressure();
        test_range_error();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
